// File: rtl/can_ctrl_pkg.sv
// Shared constants, drain FSM encoding and PeliCAN frame-length helper for the
// SJA1000 register-port controller.
package can_ctrl_pkg;

  localparam logic [7:0] SR_ADDR  = 8'd2;
  localparam logic [7:0] CMR_ADDR = 8'd1;
  localparam logic [7:0] RXB_BASE = 8'd16;
  localparam logic [7:0] CMR_RRB  = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_POLL = 3'd1,
    ST_INFO = 3'd2,
    ST_RDB  = 3'd3,
    ST_PUSH = 3'd4,
    ST_REL  = 3'd5
  } drain_state_e;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_ENG  = 1'b1
  } owner_e;

  // Bytes in the RX window: info + ID (2 std / 4 ext) + data (none for RTR, DLC capped at 8).
  function automatic logic [3:0] frame_len(input logic [7:0] info);
    logic [3:0] dlc;
    dlc = (info[3:0] > 4'd8) ? 4'd8 : info[3:0];
    return 4'd1 + (info[7] ? 4'd4 : 4'd2) + (info[6] ? 4'd0 : dlc);
  endfunction

endpackage

// File: rtl/can_reg_arb.sv
// Two-port round-robin access engine for the 8-bit core register port:
// strobe on cycle 0, writes complete on cycle 1, reads on cycle READ_LAT.
module can_reg_arb
  import can_ctrl_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic       aclk,
  input  logic       arst,
  input  logic       h_req,
  input  logic       h_we,
  input  logic [7:0] h_addr,
  input  logic [7:0] h_wdata,
  output logic       h_done,
  output logic [7:0] h_rdata,
  input  logic       e_req,
  input  logic       e_we,
  input  logic [7:0] e_addr,
  input  logic [7:0] e_wdata,
  output logic       e_done,
  output logic [7:0] e_rdata,
  output logic       reg_re,
  output logic       reg_we,
  output logic [7:0] reg_addr_read,
  output logic [7:0] reg_addr_write,
  output logic [7:0] reg_data_in,
  input  logic [7:0] reg_data_out
);

  localparam logic [1:0] RLAT = 2'(READ_LAT);

  logic       busy;
  owner_e     owner;
  logic       we_q;
  logic [1:0] cnt;
  owner_e     rr;

  logic       start;
  owner_e     win;
  logic       sel_we;
  logic [7:0] sel_addr;
  logic [7:0] sel_wdata;
  logic       complete;

  always_comb begin
    start = 1'b0;
    win   = OWN_HOST;
    if (!busy) begin
      if (h_req && e_req) begin
        start = 1'b1;
        win   = rr;
      end else if (h_req) begin
        start = 1'b1;
        win   = OWN_HOST;
      end else if (e_req) begin
        start = 1'b1;
        win   = OWN_ENG;
      end
    end
  end

  assign sel_we    = (win == OWN_ENG) ? e_we    : h_we;
  assign sel_addr  = (win == OWN_ENG) ? e_addr  : h_addr;
  assign sel_wdata = (win == OWN_ENG) ? e_wdata : h_wdata;

  // Address and data are only driven during the strobe cycle; zero otherwise.
  assign reg_re         = start & ~sel_we;
  assign reg_we         = start & sel_we;
  assign reg_addr_read  = reg_re ? sel_addr  : 8'h00;
  assign reg_addr_write = reg_we ? sel_addr  : 8'h00;
  assign reg_data_in    = reg_we ? sel_wdata : 8'h00;

  assign complete = busy && (cnt == (we_q ? 2'd1 : RLAT));
  assign h_done   = complete && (owner == OWN_HOST);
  assign e_done   = complete && (owner == OWN_ENG);
  assign h_rdata  = (h_done && !we_q) ? reg_data_out : 8'h00;
  assign e_rdata  = (e_done && !we_q) ? reg_data_out : 8'h00;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      busy  <= 1'b0;
      owner <= OWN_HOST;
      we_q  <= 1'b0;
      cnt   <= 2'd0;
      rr    <= OWN_HOST;
    end else if (start) begin
      busy  <= 1'b1;
      owner <= win;
      we_q  <= sel_we;
      cnt   <= 2'd1;
      rr    <= (win == OWN_HOST) ? OWN_ENG : OWN_HOST;
    end else if (complete) begin
      busy <= 1'b0;
      cnt  <= 2'd0;
    end else if (busy) begin
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/can_rx_drain_ctrl.sv
// SJA1000 register-port sequencer: shares the port between host and an RX-drain
// engine that polls SR, streams each received frame out and releases the buffer.
//
//  state | meaning
//  IDLE  | poll timer counting down while enabled
//  POLL  | read SR, RBS decides whether a frame is waiting
//  INFO  | read frame info byte, derive frame length
//  RDB   | read next RX window byte
//  PUSH  | hold byte on stream until accepted
//  REL   | write Release Receive Buffer, count frame
module can_rx_drain_ctrl
  import can_ctrl_pkg::*;
#(
  parameter int POLL_CYCLES = 256,
  parameter int READ_LAT    = 1
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic        enable_i,
  input  logic        h_req_i,
  input  logic        h_we_i,
  input  logic [7:0]  h_addr_i,
  input  logic [7:0]  h_wdata_i,
  output logic        h_done_o,
  output logic [7:0]  h_rdata_o,
  output logic        reg_re_o,
  output logic        reg_we_o,
  output logic [7:0]  reg_addr_read_o,
  output logic [7:0]  reg_addr_write_o,
  output logic [7:0]  reg_data_in_o,
  input  logic [7:0]  reg_data_out_i,
  output logic [7:0]  m_data_o,
  output logic        m_last_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [15:0] frames_o
);

  localparam int          TW         = $clog2(POLL_CYCLES);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(POLL_CYCLES - 1);

  drain_state_e  state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [3:0]    idx, idx_nxt;
  logic [3:0]    len, len_nxt;
  logic [7:0]    hold, hold_nxt;
  logic [15:0]   frames, frames_nxt;

  logic       e_req;
  logic       e_we;
  logic [7:0] e_addr;
  logic [7:0] e_wdata;
  logic       e_done;
  logic [7:0] e_rdata;
  logic       last;

  can_reg_arb #(
    .READ_LAT(READ_LAT)
  ) u_arb (
    .aclk          (aclk),
    .arst          (arst),
    .h_req         (h_req_i),
    .h_we          (h_we_i),
    .h_addr        (h_addr_i),
    .h_wdata       (h_wdata_i),
    .h_done        (h_done_o),
    .h_rdata       (h_rdata_o),
    .e_req         (e_req),
    .e_we          (e_we),
    .e_addr        (e_addr),
    .e_wdata       (e_wdata),
    .e_done        (e_done),
    .e_rdata       (e_rdata),
    .reg_re        (reg_re_o),
    .reg_we        (reg_we_o),
    .reg_addr_read (reg_addr_read_o),
    .reg_addr_write(reg_addr_write_o),
    .reg_data_in   (reg_data_in_o),
    .reg_data_out  (reg_data_out_i)
  );

  assign last = (idx == (len - 4'd1));

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    idx_nxt    = idx;
    len_nxt    = len;
    hold_nxt   = hold;
    frames_nxt = frames;
    e_req      = 1'b0;
    e_we       = 1'b0;
    e_addr     = 8'h00;
    e_wdata    = 8'h00;
    m_valid_o  = 1'b0;
    m_last_o   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable_i) begin
          if (timer == '0) begin
            state_nxt = ST_POLL;
            timer_nxt = TIMER_LOAD;
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
      end
      ST_POLL: begin
        e_req  = 1'b1;
        e_addr = SR_ADDR;
        // A poll started before enable dropped still completes, but its result is dropped.
        if (e_done) state_nxt = (enable_i && e_rdata[0]) ? ST_INFO : ST_IDLE;
      end
      ST_INFO: begin
        e_req  = 1'b1;
        e_addr = RXB_BASE;
        if (e_done) begin
          hold_nxt  = e_rdata;
          len_nxt   = frame_len(e_rdata);
          idx_nxt   = 4'd0;
          state_nxt = ST_PUSH;
        end
      end
      ST_RDB: begin
        e_req  = 1'b1;
        e_addr = RXB_BASE + {4'd0, idx};
        if (e_done) begin
          hold_nxt  = e_rdata;
          state_nxt = ST_PUSH;
        end
      end
      ST_PUSH: begin
        m_valid_o = 1'b1;
        m_last_o  = last;
        if (m_ready_i) begin
          idx_nxt   = idx + 4'd1;
          state_nxt = last ? ST_REL : ST_RDB;
        end
      end
      ST_REL: begin
        e_req   = 1'b1;
        e_we    = 1'b1;
        e_addr  = CMR_ADDR;
        e_wdata = CMR_RRB;
        if (e_done) begin
          frames_nxt = frames + 16'd1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state  <= ST_IDLE;
      timer  <= TIMER_LOAD;
      idx    <= 4'd0;
      len    <= 4'd0;
      hold   <= 8'h00;
      frames <= 16'd0;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      idx    <= idx_nxt;
      len    <= len_nxt;
      hold   <= hold_nxt;
      frames <= frames_nxt;
    end
  end

  assign m_data_o = hold;
  assign frames_o = frames;

endmodule
